// File: rtl/rom_load_pkg.sv
// Shared types and helpers for the ROM download sequencer.
package rom_load_pkg;

    // Sequencer states; reset lands in ST_FAULT so the core never runs without a good image.
    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_FAULT
    } state_t;

    // ROM region indices, selected by byte address bits [15:14].
    localparam logic [1:0] REG_PROG  = 2'd0;
    localparam logic [1:0] REG_PROG2 = 2'd1;
    localparam logic [1:0] REG_GFX   = 2'd2;
    localparam logic [1:0] REG_PROM  = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] sel;
        sel = 4'b0000;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Download-side (ioctl) inputs and ROM-side write bus of the sequencer.
interface rom_load_ctrl_if;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rom_wr;
    logic [3:0]  rom_cs;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;

    // Download source: drives ioctl signals, observes the ROM writes.
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  rom_wr, rom_cs, rom_addr, rom_data
    );

    // Sequencer side.
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output rom_wr, rom_cs, rom_addr, rom_data
    );
endinterface

// File: rtl/rom_wr_pipe.sv
// One-stage registered ROM write path: range check, region decode, data capture.
module rom_wr_pipe
    import rom_load_pkg::*;
#(
    parameter logic [16:0] EXP_LEN = 17'h10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        in_range,
    output logic        rom_wr,
    output logic [3:0]  rom_cs,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data
);
    logic        issue;
    logic        wr_p1;
    logic [3:0]  cs_p1;
    logic [13:0] addr_p1;
    logic [7:0]  data_p1;

    // Any set bit in [24:17] makes the address exceed EXP_LEN, so one compare covers both overrun cases.
    assign in_range = (dl_addr < {8'd0, EXP_LEN});
    assign issue    = accept & dl_wr & in_range;

    // Stage p0 -> p1: strobe and select live for one cycle; address and data hold until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_p1   <= 1'b0;
            cs_p1   <= 4'd0;
            addr_p1 <= 14'd0;
            data_p1 <= 8'd0;
        end else begin
            wr_p1 <= issue;
            cs_p1 <= issue ? onehot4(dl_addr[15:14]) : 4'd0;
            if (issue) begin
                addr_p1 <= dl_addr[13:0];
                data_p1 <= dl_data;
            end
        end
    end

    assign rom_wr   = wr_p1;
    assign rom_cs   = cs_p1;
    assign rom_addr = addr_p1;
    assign rom_data = data_p1;
endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the arcade core around an HPS ROM download: reset while loading,
// length check at the end, programmable reset hold, user reset requests.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [16:0] EXP_LEN  = 17'h10000,
    parameter int unsigned HOLD_CYC = 1024,
    parameter int unsigned HOLD_W   = 11
) (
    input  logic           CLK,
    input  logic           RESET_N,
    rom_load_ctrl_if.slave bus,
    input  logic           rst_req,
    output logic           core_reset,
    output logic           load_ok,
    output logic           load_err,
    output logic           busy
);
    localparam logic [16:0]       CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_t            state, state_nxt;
    logic [16:0]       byte_cnt, byte_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              overrun, overrun_nxt;
    logic              load_ok_nxt, load_err_nxt;
    logic              start_load;
    logic              accept;
    logic              in_range;

    // Bytes are only taken while already in LOAD, so a strobe coinciding with the rising edge of dl_active is dropped.
    assign accept = (state == ST_LOAD);

    rom_wr_pipe #(.EXP_LEN(EXP_LEN)) u_wr_pipe (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .accept   (accept),
        .dl_wr    (bus.dl_wr),
        .dl_addr  (bus.dl_addr),
        .dl_data  (bus.dl_data),
        .in_range (in_range),
        .rom_wr   (bus.rom_wr),
        .rom_cs   (bus.rom_cs),
        .rom_addr (bus.rom_addr),
        .rom_data (bus.rom_data)
    );

    // A new download preempts RUN, HOLD and FAULT.
    assign start_load = bus.dl_active &&
                        ((state == ST_RUN) || (state == ST_HOLD) || (state == ST_FAULT));

    // Next-state and next-counter logic.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        hold_cnt_nxt = hold_cnt;
        overrun_nxt  = overrun;
        load_ok_nxt  = load_ok;
        load_err_nxt = load_err;
        case (state)
            ST_RUN: begin
                if (rst_req) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            ST_LOAD: begin
                if (bus.dl_wr) begin
                    if (byte_cnt != CNT_MAX) byte_cnt_nxt = byte_cnt + 17'd1;
                    if (!in_range) overrun_nxt = 1'b1;
                end
                if (!bus.dl_active) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if ((byte_cnt == EXP_LEN) && !overrun) begin
                    load_ok_nxt  = 1'b1;
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end else begin
                    load_err_nxt = 1'b1;
                    state_nxt    = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (rst_req) hold_cnt_nxt = '0;
                else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
                else hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: state_nxt = ST_FAULT;
        endcase
        if (start_load) begin
            state_nxt    = ST_LOAD;
            byte_cnt_nxt = '0;
            overrun_nxt  = 1'b0;
            load_ok_nxt  = 1'b0;
            load_err_nxt = 1'b0;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_FAULT;
            byte_cnt <= '0;
            hold_cnt <= '0;
            overrun  <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            overrun  <= overrun_nxt;
            load_ok  <= load_ok_nxt;
            load_err <= load_err_nxt;
        end
    end

    assign core_reset = (state != ST_RUN);
    assign busy       = (state == ST_LOAD) || (state == ST_HOLD);
endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed-sequence bench with randomized bytes/addresses for rom_load_ctrl.
// dut_s uses a short image and hold so whole download cycles fit in a short run;
// dut_b keeps the default 64 KiB geometry to exercise all four ROM regions.
module tb_rom_load_ctrl;
    localparam logic [16:0] S_EXP  = 17'h00100;
    localparam int          S_HOLD = 64;
    localparam logic [16:0] B_EXP  = 17'h10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_req = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = 25'd0;
    logic [7:0]  dl_data = 8'd0;

    logic s_core_reset, s_ok, s_err, s_busy;
    logic b_core_reset, b_ok, b_err, b_busy;

    int errors = 0;
    int checks = 0;
    int m_cnt;
    bit m_over;

    rom_load_ctrl_if sif();
    rom_load_ctrl_if bif();

    assign sif.dl_active = dl_active;
    assign sif.dl_wr     = dl_wr;
    assign sif.dl_addr   = dl_addr;
    assign sif.dl_data   = dl_data;
    assign bif.dl_active = dl_active;
    assign bif.dl_wr     = dl_wr;
    assign bif.dl_addr   = dl_addr;
    assign bif.dl_data   = dl_data;

    rom_load_ctrl #(.EXP_LEN(S_EXP), .HOLD_CYC(S_HOLD), .HOLD_W(7)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .bus(sif.slave), .rst_req(rst_req),
        .core_reset(s_core_reset), .load_ok(s_ok), .load_err(s_err), .busy(s_busy)
    );

    rom_load_ctrl dut_b (
        .CLK(clk), .RESET_N(rst_n), .bus(bif.slave), .rst_req(rst_req),
        .core_reset(b_core_reset), .load_ok(b_ok), .load_err(b_err), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] in_addr(input logic [16:0] lim);
        return 25'($urandom_range(32'(lim) - 32'd1, 32'd0));
    endfunction

    function automatic logic [24:0] out_addr(input logic [16:0] lim);
        if ($urandom_range(0, 1) == 0) return 25'(lim) + 25'($urandom_range(0, 255));
        return 25'h1000000 | in_addr(lim);
    endfunction

    // One clock of download stimulus; the model decides whether a write must appear one cycle later.
    task automatic cyc(input bit big, input bit act, input bit wr, input logic [24:0] a,
                       input logic [7:0] d, input bit accepting);
        logic [16:0] lim;
        bit          exp_wr;
        logic        o_wr;
        logic [3:0]  o_cs;
        logic [13:0] o_addr;
        logic [7:0]  o_data;
        int          region;
        lim = big ? B_EXP : S_EXP;
        dl_active = act;
        dl_wr     = wr;
        dl_addr   = a;
        dl_data   = d;
        tick();
        dl_wr = 1'b0;
        o_wr   = big ? bif.rom_wr   : sif.rom_wr;
        o_cs   = big ? bif.rom_cs   : sif.rom_cs;
        o_addr = big ? bif.rom_addr : sif.rom_addr;
        o_data = big ? bif.rom_data : sif.rom_data;
        exp_wr = accepting && wr && (int'(a) < int'(lim));
        chk("rom_wr", 32'(o_wr), 32'(exp_wr));
        if (exp_wr) begin
            region = (int'(a) % 65536) / 16384;
            chk("rom_cs", 32'(o_cs), 32'(1) << region);
            chk("rom_addr", 32'(o_addr), 32'(int'(a) % 16384));
            chk("rom_data", 32'(o_data), 32'(d));
        end else begin
            chk("rom_cs_idle", 32'(o_cs), 32'd0);
        end
        if (accepting && wr) begin
            m_cnt++;
            if (int'(a) >= int'(lim)) m_over = 1'b1;
        end
    endtask

    // Full download into dut_s: optional rising cycle, n_good in-range bytes, n_over out-of-range
    // bytes, last byte on the falling cycle, then the one-cycle length check.
    task automatic load_s(input bit rise, input bit wr_on_rise, input int n_good, input int n_over);
        int total;
        bit good;
        logic [24:0] a;
        total  = n_good + n_over;
        m_cnt  = 0;
        m_over = 1'b0;
        if (rise) cyc(1'b0, 1'b1, wr_on_rise, in_addr(S_EXP), 8'($urandom), 1'b0);
        for (int i = 0; i < total; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b1, 1'b0, 25'd0, 8'd0, 1'b1);
            a = (i < n_good) ? in_addr(S_EXP) : out_addr(S_EXP);
            cyc(1'b0, (i != total - 1), 1'b1, a, 8'($urandom), 1'b1);
        end
        chk("check_ok", 32'(s_ok), 32'd0);
        chk("check_err", 32'(s_err), 32'd0);
        chk("check_busy", 32'(s_busy), 32'd0);
        chk("check_core_reset", 32'(s_core_reset), 32'd1);
        tick();
        good = (m_cnt == int'(S_EXP)) && !m_over;
        chk("load_ok", 32'(s_ok), 32'(good));
        chk("load_err", 32'(s_err), 32'(!good));
        chk("busy_after_check", 32'(s_busy), 32'(good));
        chk("core_reset_after_check", 32'(s_core_reset), 32'd1);
    endtask

    // Counts cycles with core_reset high, starting at the current sample.
    task automatic hold_len(output int n);
        n = 0;
        while (s_core_reset && n < 4 * S_HOLD) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int k;
        logic [24:0] a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(s_core_reset), 32'd1);
        chk("rst_rom_wr", 32'(sif.rom_wr), 32'd0);
        chk("rst_rom_cs", 32'(sif.rom_cs), 32'd0);
        chk("rst_rom_addr", 32'(sif.rom_addr), 32'd0);
        chk("rst_rom_data", 32'(sif.rom_data), 32'd0);
        chk("rst_load_ok", 32'(s_ok), 32'd0);
        chk("rst_load_err", 32'(s_err), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_b_core_reset", 32'(b_core_reset), 32'd1);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;

        // Power-up idle: stays in FAULT, rst_req ignored
        for (int i = 0; i < 200; i++) begin
            rst_req = (i >= 50 && i < 100);
            tick();
            chk("pwrup_core_reset", 32'(s_core_reset), 32'd1);
            chk("pwrup_b_core_reset", 32'(b_core_reset), 32'd1);
        end
        rst_req = 1'b0;
        chk("pwrup_busy", 32'(s_busy), 32'd0);
        chk("pwrup_load_ok", 32'(s_ok), 32'd0);
        chk("pwrup_load_err", 32'(s_err), 32'd0);

        // Region decode on the full-size instance (dut_s also sees this and faults)
        cyc(1'b1, 1'b1, 1'b0, 25'd0, 8'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 25'h0004005, 8'hA5, 1'b1);
        chk("spec_cs_4005", 32'(bif.rom_cs), 32'h2);
        chk("spec_addr_4005", 32'(bif.rom_addr), 32'h5);
        chk("spec_data_4005", 32'(bif.rom_data), 32'hA5);
        for (int r = 0; r < 4; r++) begin
            a = 25'(r * 16384 + int'($urandom_range(0, 16383)));
            cyc(1'b1, 1'b1, 1'b1, a, 8'($urandom), 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 25'd0, 8'd0, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1, 25'h0010000, 8'h5A, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 25'h1000123, 8'h3C, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 25'h000C123, 8'($urandom), 1'b1);
        chk("b_check_err", 32'(b_err), 32'd0);
        tick();
        chk("b_load_err", 32'(b_err), 32'd1);
        chk("b_load_ok", 32'(b_ok), 32'd0);
        chk("b_busy", 32'(b_busy), 32'd0);
        chk("b_core_reset", 32'(b_core_reset), 32'd1);

        // Short load, then FAULT ignores rst_req
        load_s(1'b1, 1'b0, int'(S_EXP) - 1, 0);
        rst_req = 1'b1;
        repeat (20) tick();
        rst_req = 1'b0;
        chk("fault_core_reset", 32'(s_core_reset), 32'd1);
        chk("fault_busy", 32'(s_busy), 32'd0);
        chk("fault_err_kept", 32'(s_err), 32'd1);

        // Exact length plus one out-of-range byte
        load_s(1'b1, 1'b0, int'(S_EXP), 1);

        // Good load with a strobe on the rising cycle, then the post-load hold
        load_s(1'b1, 1'b1, int'(S_EXP), 0);
        hold_len(n);
        chk("hold_len_good", 32'(n), 32'(S_HOLD));
        chk("run_busy", 32'(s_busy), 32'd0);
        chk("run_ok_kept", 32'(s_ok), 32'd1);
        repeat (10) tick();
        chk("run_core_reset", 32'(s_core_reset), 32'd0);

        // User reset request in RUN: reset follows one cycle later, ends S_HOLD cycles after release
        rst_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rstreq_core_reset", 32'(s_core_reset), 32'd1);
            chk("rstreq_rom_wr", 32'(sif.rom_wr), 32'd0);
        end
        rst_req = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (s_core_reset && k < 4 * S_HOLD);
        chk("rstreq_release_len", 32'(k), 32'(S_HOLD));
        chk("rstreq_ok_kept", 32'(s_ok), 32'd1);

        // New download from RUN, aborted mid-hold by another download
        load_s(1'b1, 1'b0, int'(S_EXP), 0);
        repeat (31) tick();
        chk("midhold_core_reset", 32'(s_core_reset), 32'd1);
        dl_active = 1'b1;
        tick();
        chk("midhold_ok_cleared", 32'(s_ok), 32'd0);
        chk("midhold_err", 32'(s_err), 32'd0);
        chk("midhold_busy", 32'(s_busy), 32'd1);
        load_s(1'b0, 1'b0, int'(S_EXP), 0);
        hold_len(n);
        chk("hold_len_reload", 32'(n), 32'(S_HOLD));
        chk("reload_core_reset", 32'(s_core_reset), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the arcade core around an HPS ROM download.
- Holds the core in reset while a download is in progress, routes each downloaded byte to one of four ROM regions, and checks the total length when the download ends.
- After a successful download it holds reset for a programmable number of cycles, then releases the core. It also services user reset requests.
- Sits between hps_io's ioctl outputs and the pacman core's dn_* / RESET inputs.

Parameters:
- EXP_LEN, 17'h10000: exact byte count a valid download must contain.
- HOLD_CYC, 1024: cycles core_reset stays asserted after a good load or a rst_req.
- HOLD_W, 11: width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYC.

Ports:
- CLK  in  1  system clock (clk_sys).
- RESET_N  in  1  asynchronous, active-low reset.
- dl_active  in  1  download in progress (ioctl_download level).
- dl_wr  in  1  one-cycle byte strobe (ioctl_wr).
- dl_addr  in  25  byte address (ioctl_addr).
- dl_data  in  8  byte data (ioctl_dout).
- rst_req  in  1  user reset request, level (status[0] | buttons[1]).
- core_reset  out  1  active-high reset to the core.
- rom_wr  out  1  registered write strobe.
- rom_cs  out  4  one-hot region select, valid while rom_wr=1.
- rom_addr  out  14  offset within the region (dl_addr[13:0]).
- rom_data  out  8  registered byte.
- load_ok  out  1  last download was the exact length and had no overrun.
- load_err  out  1  last download was the wrong length or had an overrun.
- busy  out  1  high in LOAD or HOLD; drives LED_USER.

Behaviour:
- Reset state (RESET_N=0, asynchronous):
  - State is FAULT.
  - core_reset=1, rom_wr=0, rom_cs=0, rom_addr=0, rom_data=0.
  - load_ok=0, load_err=0, busy=0.
  - byte_cnt=0, hold_cnt=0, overrun=0.
  - The core runs only after a good download.
- States: LOAD, CHECK, HOLD, RUN, FAULT.
- RUN:
  - core_reset=0.
  - dl_active=1 -> LOAD.
  - else rst_req=1 -> HOLD, with hold_cnt=0.
- LOAD:
  - core_reset=1, busy=1.
  - On entry: byte_cnt=0, overrun=0, load_ok=0, load_err=0.
  - Each dl_wr:
    - If dl_addr < EXP_LEN: register a write, with rom_cs = onehot(dl_addr[15:14]), rom_addr = dl_addr[13:0], rom_data = dl_data.
    - Else: no write is issued and overrun is set.
  - byte_cnt increments on every dl_wr and saturates at 2^17-1.
  - dl_active falling -> CHECK.
- CHECK (one cycle):
  - byte_cnt==EXP_LEN and overrun=0 -> load_ok=1, go to HOLD with hold_cnt=0.
  - Otherwise -> load_err=1, go to FAULT.
- HOLD:
  - core_reset=1, busy=1.
  - hold_cnt increments each cycle.
  - hold_cnt==HOLD_CYC-1 -> RUN, so core_reset is high for exactly HOLD_CYC cycles in HOLD.
  - While rst_req=1, hold_cnt is forced to 0, which extends the hold.
  - dl_active=1 -> LOAD; this takes priority over everything else.
- FAULT:
  - core_reset=1, busy=0.
  - Exits only when dl_active=1 -> LOAD. rst_req is ignored.
- Write path latency:
  - rom_wr is asserted in the cycle after dl_wr, for exactly one cycle.
  - rom_cs/rom_addr/rom_data hold their values until the next write.
  - rom_cs=0 whenever rom_wr=0.
- Simultaneous events:
  - dl_wr in the same cycle dl_active rises: the byte is not counted or written, because writes are accepted only while in LOAD.
  - dl_wr in the same cycle dl_active falls: the byte is accepted.
- dl_addr[24:17] nonzero: counts as overrun.
- byte_cnt is 17 bits, so EXP_LEN up to 0x1FFFE can be checked without aliasing.

Decomposition:
- Package rom_load_pkg contains:
  - the state enum;
  - region index constants: REG_PROG=0, REG_PROG2=1, REG_GFX=2, REG_PROM=3;
  - the onehot4 function.
- Sub-module rom_wr_pipe: the one-stage registered write path (range check, region decode, data register). It is driven by the FSM through an accept enable.

Test Plan:
1. Power-up: release RESET_N, hold dl_active=0 for 5000 cycles -> core_reset stays 1, state FAULT, load_ok=0, load_err=0.
2. Good load: dl_active=1, write 0x10000 bytes at addresses 0..0xFFFF, drop dl_active ->
   - the write to 0x4005 (data 0xA5) gives rom_cs=4'b0010, rom_addr=0x0005, rom_data=0xA5 one cycle later;
   - load_ok=1;
   - core_reset falls exactly 1024 cycles after CHECK.
3. Short load: 0xFFFF bytes -> load_err=1, state FAULT, core_reset stays 1, busy=0.
4. Overrun: 0x10000 bytes plus one byte at 0x10000 -> no rom_wr for the extra byte, load_err=1.
5. rst_req in RUN for 300 cycles -> core_reset high for 300+1024 cycles, no rom_wr, load_ok remains 1.
6. Mid-HOLD download: raise dl_active at hold_cnt=500 -> immediate LOAD, byte_cnt=0, load_ok cleared; a good reload then completes normally.
